// File: rtl/pkt_bank_buffer.sv
// Multi-bank packet buffer: sensor words fill fixed-size banks while
// completed packets are read out whole from the oldest filled bank.
module pkt_bank_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_SIZE   = 60,
  parameter int NUM_BANKS  = 2,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [DATA_WIDTH-1:0]            din,
  input  logic                             wr_abort,
  input  logic                             rd_en,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic                             valid,
  output logic                             rd_last,
  output logic                             pkt_ready,
  output logic                             full,
  output logic [$clog2(NUM_BANKS+1)-1:0]   pkt_cnt,
  output logic                             overflow,
  output logic [15:0]                      drop_cnt
);

  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int CNT_W  = $clog2(NUM_BANKS + 1);

  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][PKT_SIZE];

  logic [BANK_W-1:0]     wb_q, wb_d, rb_q, rb_d;
  logic [ADDR_WIDTH-1:0] wa_q, wa_d, ra_q, ra_d;
  logic [CNT_W-1:0]      pkt_cnt_q, pkt_cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  rd_last_q, rd_last_d;
  logic                  overflow_q, overflow_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;

  logic                  full_w, ready_w;
  logic                  wr_accept, wr_drop, wr_complete;
  logic                  rd_accept, rd_release;
  logic [DATA_WIDTH-1:0] rd_word;

  // Advance a bank pointer, wrapping at NUM_BANKS which need not be a power of 2
  function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
    return (b == BANK_W'(NUM_BANKS - 1)) ? '0 : b + BANK_W'(1);
  endfunction

  // Packet-granular status and the accept/drop/complete/release qualifiers
  always_comb begin
    full_w      = (pkt_cnt_q == CNT_W'(NUM_BANKS));
    ready_w     = (pkt_cnt_q != '0);
    wr_accept   = wr_en & ~full_w & ~wr_abort;
    wr_drop     = wr_en &  full_w & ~wr_abort;
    wr_complete = wr_accept & (wa_q == ADDR_WIDTH'(PKT_SIZE - 1));
    rd_accept   = rd_en & ready_w;
    rd_release  = rd_accept & (ra_q == ADDR_WIDTH'(PKT_SIZE - 1));
    rd_word     = mem[rb_q][ra_q];
  end

  // Write-side pointers: abort rewinds the partial packet, completion moves to the next bank
  always_comb begin
    wa_d = wa_q;
    wb_d = wb_q;
    if (wr_abort) begin
      wa_d = '0;
    end else if (wr_accept) begin
      if (wr_complete) begin
        wa_d = '0;
        wb_d = next_bank(wb_q);
      end else begin
        wa_d = wa_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Read-side pointers and the registered read data path
  always_comb begin
    ra_d      = ra_q;
    rb_d      = rb_q;
    dout_d    = dout_q;
    valid_d   = rd_accept;
    rd_last_d = rd_release;
    if (rd_accept) begin
      dout_d = rd_word;
      if (rd_release) begin
        ra_d = '0;
        rb_d = next_bank(rb_q);
      end else begin
        ra_d = ra_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Packet count, overflow pulse and saturating drop counter
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    overflow_d = wr_drop;
    drop_cnt_d = drop_cnt_q;
    if (wr_complete && !rd_release) begin
      pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
    end else if (rd_release && !wr_complete) begin
      pkt_cnt_d = pkt_cnt_q - CNT_W'(1);
    end
    if (wr_drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Packet storage; contents are left untouched by reset
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wb_q][wa_q] <= din;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q       <= '0;
      wa_q       <= '0;
      rb_q       <= '0;
      ra_q       <= '0;
      pkt_cnt_q  <= '0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      rd_last_q  <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wb_q       <= wb_d;
      wa_q       <= wa_d;
      rb_q       <= rb_d;
      ra_q       <= ra_d;
      pkt_cnt_q  <= pkt_cnt_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      rd_last_q  <= rd_last_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign dout      = dout_q;
  assign valid     = valid_q;
  assign rd_last   = rd_last_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign pkt_ready = ready_w;
  assign full      = full_w;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
